// File: rtl/fir_pkg.sv
// Shared sample type for the fir filter and its downstream stages.
package fir_pkg;
  localparam int SAMPLE_W = 16;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/sample_fifo.sv
// Sample FIFO with wrap-bit pointers; head is combinational from storage.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: caller must not push when full unless popping in the same cycle.
module sample_fifo
  import fir_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  sample_t din,
  output sample_t head,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);

  sample_t        mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  sample_t        last_q;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // When empty the head shows the last popped value (0 after reset), never stale storage.
  assign head  = empty ? last_q : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        last_q <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/fir_decimator.sv
// Keeps one of every DECIM valid fir samples and queues them on a ready/valid port.
// Latency: kept sample visible one cycle later; FIFO full without a pop drops it and sets overflow.
// Optional drop counter port enabled by FIR_DECIM_DROPCNT_EN.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_sample,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_sample,
  output logic                overflow
`ifdef FIR_DECIM_DROPCNT_EN
  ,
  output logic [15:0]         drop_cnt
`endif
);
  localparam int PHASE_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DECIM - 1);

  logic [PHASE_W-1:0] phase;
  logic               keep;
  logic               pop;
  logic               push;
  logic               drop;
  logic               full;
  logic               empty;
  sample_t            head;

  assign keep      = in_valid && (phase == '0);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign push      = keep && (!full || pop);
  assign drop      = keep && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (in_valid) begin
      phase <= (phase == PHASE_LAST) ? '0 : phase + PHASE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef FIR_DECIM_DROPCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

  sample_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (sample_t'(in_sample)),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign out_sample = head;
endmodule

// File: tb/tb_fir_decimator.sv
// Scoreboard bench: four decimator instances (DECIM 4, 3, 1, 2) exercised in turn.
module tb_fir_decimator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv   [4];
  logic [15:0] isd  [4];
  logic        ordy [4];
  logic        ov   [4];
  logic [15:0] os   [4];
  logic        ovf  [4];
`ifdef FIR_DECIM_DROPCNT_EN
  logic [15:0] dcnt [4];
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [15:0] sb_dat [4][1024];
  int          sb_cyc [4][1024];
  int          sb_wr  [4];
  int          sb_rd  [4];

  logic        hold_prev = 1'b0;
  logic [15:0] hold_s    = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_decimator #(.DECIM(4), .FIFO_DEPTH(8)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_sample(isd[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_sample(os[0]), .overflow(ovf[0])
`ifdef FIR_DECIM_DROPCNT_EN
    , .drop_cnt(dcnt[0])
`endif
  );
  fir_decimator #(.DECIM(3), .FIFO_DEPTH(8)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_sample(isd[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_sample(os[1]), .overflow(ovf[1])
`ifdef FIR_DECIM_DROPCNT_EN
    , .drop_cnt(dcnt[1])
`endif
  );
  fir_decimator #(.DECIM(1), .FIFO_DEPTH(8)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_sample(isd[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .out_sample(os[2]), .overflow(ovf[2])
`ifdef FIR_DECIM_DROPCNT_EN
    , .drop_cnt(dcnt[2])
`endif
  );
  fir_decimator #(.DECIM(2), .FIFO_DEPTH(8)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_sample(isd[3]), .out_valid(ov[3]),
    .out_ready(ordy[3]), .out_sample(os[3]), .overflow(ovf[3])
`ifdef FIR_DECIM_DROPCNT_EN
    , .drop_cnt(dcnt[3])
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected cycle -1 means latency is not checked for that entry.
  task automatic expect_out(input int k, input logic [15:0] v, input int c);
    sb_dat[k][sb_wr[k]] = v;
    sb_cyc[k][sb_wr[k]] = c;
    sb_wr[k]++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int k, input string name);
    int n = 0;
    while (sb_rd[k] != sb_wr[k] && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_consumed"}, sb_rd[k], sb_wr[k]);
    check({name, "_valid_low"}, {31'd0, ov[k]}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (ov[k] && ordy[k]) begin
          if (sb_rd[k] == sb_wr[k]) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out inst=%0d actual=%0h expected=none", k, os[k]);
          end else begin
            check($sformatf("out_sample_i%0d_n%0d", k, sb_rd[k]), {16'd0, os[k]}, {16'd0, sb_dat[k][sb_rd[k]]});
            if (sb_cyc[k][sb_rd[k]] >= 0)
              check($sformatf("latency_i%0d_n%0d", k, sb_rd[k]), cyc, sb_cyc[k][sb_rd[k]]);
            sb_rd[k]++;
          end
        end
      end
      if (hold_prev) check("hold_stable", {15'd0, ov[3], os[3]}, {15'd0, 1'b1, hold_s});
      hold_prev <= ov[3] && !ordy[3];
      hold_s    <= os[3];
    end else begin
      hold_prev <= 1'b0;
    end
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      iv[k] = 1'b0; isd[k] = '0; ordy[k] = 1'b0; sb_wr[k] = 0; sb_rd[k] = 0;
    end
    #3;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_valid_i%0d", k), {31'd0, ov[k]}, 32'd0);
      check($sformatf("rst_sample_i%0d", k), {16'd0, os[k]}, 32'd0);
      check($sformatf("rst_overflow_i%0d", k), {31'd0, ovf[k]}, 32'd0);
    end
    #9 rst = 1'b0;
    step();

    // DECIM=4, consecutive inputs 0..15
    ordy[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      iv[0] = 1'b1; isd[0] = 16'(i);
      if (i % 4 == 0) expect_out(0, 16'(i), cyc + 1);
      step();
    end
    iv[0] = 1'b0;
    drain(0, "plain");
    check("plain_overflow", {31'd0, ovf[0]}, 32'd0);

    // DECIM=3, valid every other cycle; bubble data must be ignored
    ordy[1] = 1'b1;
    for (int i = 0; i < 18; i++) begin
      iv[1] = (i % 2 == 0);
      isd[1] = (i % 2 == 0) ? 16'(100 + i / 2) : 16'hDEAD;
      if (i % 2 == 0 && (i / 2) % 3 == 0) expect_out(1, 16'(100 + i / 2), cyc + 1);
      step();
    end
    iv[1] = 1'b0;
    drain(1, "gapped");

    // DECIM=1: fill, then push while popping on a full FIFO
    ordy[2] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      iv[2] = 1'b1; isd[2] = 16'(8'h11 + i);
      expect_out(2, 16'(8'h11 + i), -1);
      step();
    end
    iv[2] = 1'b1; isd[2] = 16'h7FFF; ordy[2] = 1'b1;
    expect_out(2, 16'h7FFF, -1);
    step();
    iv[2] = 1'b0; ordy[2] = 1'b0;
    step();
    check("fullpop_valid", {31'd0, ov[2]}, 32'd1);
    check("fullpop_overflow", {31'd0, ovf[2]}, 32'd0);
    ordy[2] = 1'b1;
    drain(2, "fullpop");
    check("fullpop_overflow_end", {31'd0, ovf[2]}, 32'd0);

    // DECIM=1 overflow: 10 inputs into 8 entries with consumer stalled
    ordy[2] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      iv[2] = 1'b1; isd[2] = 16'(i);
      if (i <= 8) expect_out(2, 16'(i), -1);
      step();
      check($sformatf("ovf_valid_n%0d", i), {31'd0, ov[2]}, 32'd1);
      check($sformatf("ovf_flag_n%0d", i), {31'd0, ovf[2]}, (i >= 9) ? 32'd1 : 32'd0);
    end
    iv[2] = 1'b0;
`ifdef FIR_DECIM_DROPCNT_EN
    check("drop_cnt", {16'd0, dcnt[2]}, 32'd2);
`endif
    ordy[2] = 1'b1;
    drain(2, "overflow");
    check("overflow_sticky", {31'd0, ovf[2]}, 32'd1);

    // DECIM=2 with random consumer stalls
    for (int i = 0; i < 1000; i++) begin
      iv[3] = 1'b1; isd[3] = 16'(i * 7 + 3);
      if (i % 2 == 0) expect_out(3, 16'(i * 7 + 3), -1);
      ordy[3] = ($urandom_range(0, 3) != 0);
      step();
    end
    iv[3] = 1'b0; ordy[3] = 1'b1;
    drain(3, "backpressure");
    check("backpressure_overflow", {31'd0, ovf[3]}, 32'd0);

    // DECIM=4: queue 5 entries leaving phase at 2, then reset between edges
    ordy[0] = 1'b0;
    for (int i = 0; i < 18; i++) begin
      iv[0] = 1'b1; isd[0] = 16'(200 + i);
      step();
    end
    iv[0] = 1'b0;
    check("prerst_valid", {31'd0, ov[0]}, 32'd1);
    check("prerst_head", {16'd0, os[0]}, 32'd200);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", {31'd0, ov[0]}, 32'd0);
    check("midrst_sample", {16'd0, os[0]}, 32'd0);
    check("midrst_overflow", {31'd0, ovf[2]}, 32'd0);
    #2 rst = 1'b0;
    step();
    ordy[0] = 1'b1; iv[0] = 1'b1; isd[0] = 16'h8000;
    expect_out(0, 16'h8000, cyc + 1);
    step();
    iv[0] = 1'b0;
    drain(0, "postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
